light_sequencer: RTL and testbench

Phase controller that drives the traffic intersection. It issues a 6-bit phase duration on `timer_value` to the downstream down-counter and watches the returned `counter_value`. When that count reaches zero, it advances through the NS/EW green, yellow and all-red cycle, or through the night-flash cycle. It is the command side of the counter interface: it writes the durations that the counter consumes.

---
 rtl/traffic_pkg.sv | 22 ++
 rtl/light_sequencer.sv | 158 +++++++++++++++
 tb/tb_light_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller and its down-counter.
package traffic_pkg;

   localparam int TW = 6;

   typedef enum logic [2:0] {
      NS_G   = 3'd0,
      NS_Y   = 3'd1,
      AR1    = 3'd2,
      EW_G   = 3'd3,
      EW_Y   = 3'd4,
      AR2    = 3'd5,
      FL_ON  = 3'd6,
      FL_OFF = 3'd7
   } phase_t;

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;
   localparam logic [2:0] OFF = 3'b000;

endpackage

// File: rtl/light_sequencer.sv
// Traffic phase sequencer: commands phase durations to the down-counter and
// advances when the returned count reaches zero.
//
//  state  | meaning
//  -------+--------------------------------------------
//  NS_G   | north-south green, east-west red
//  NS_Y   | north-south yellow, east-west red
//  AR1    | all-red clearance before east-west green
//  EW_G   | east-west green, north-south red
//  EW_Y   | east-west yellow, north-south red
//  AR2    | all-red clearance before north-south green
//  FL_ON  | night mode, both yellow
//  FL_OFF | night mode, both dark
module light_sequencer
   import traffic_pkg::*;
#(
   parameter int T_NS_GREEN  = 30,
   parameter int T_EW_GREEN  = 25,
   parameter int T_YELLOW    = 3,
   parameter int T_ALL_RED   = 2,
   parameter int T_FLASH_ON  = 4,
   parameter int T_FLASH_OFF = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          night,
   input  logic [TW-1:0] counter_value,
   output logic [TW-1:0] timer_value,
   output logic [2:0]    phase,
   output logic [2:0]    ns_light,
   output logic [2:0]    ew_light,
   output logic          phase_done
);

   // The counter only reloads when timer_value changes, so any two durations
   // that can follow each other must differ.
   localparam bit BAD_RANGE =
      (T_NS_GREEN  < 1) || (T_NS_GREEN  > 63) ||
      (T_EW_GREEN  < 1) || (T_EW_GREEN  > 63) ||
      (T_YELLOW    < 1) || (T_YELLOW    > 63) ||
      (T_ALL_RED   < 1) || (T_ALL_RED   > 63) ||
      (T_FLASH_ON  < 1) || (T_FLASH_ON  > 63) ||
      (T_FLASH_OFF < 1) || (T_FLASH_OFF > 63);

   localparam bit BAD_ADJACENT =
      (T_YELLOW == T_NS_GREEN) || (T_YELLOW == T_EW_GREEN) ||
      (T_YELLOW == T_ALL_RED) ||
      (T_ALL_RED == T_NS_GREEN) || (T_ALL_RED == T_EW_GREEN) ||
      (T_FLASH_ON == T_NS_GREEN) || (T_FLASH_ON == T_EW_GREEN) ||
      (T_FLASH_ON == T_YELLOW) || (T_FLASH_ON == T_ALL_RED) ||
      (T_FLASH_ON == T_FLASH_OFF) ||
      (T_FLASH_OFF == T_ALL_RED);

   if (BAD_RANGE) begin : g_bad_range
      $error("light_sequencer: every duration must be in 1..63");
   end

   if (BAD_ADJACENT) begin : g_bad_adjacent
      $error("light_sequencer: adjacent phase durations must differ");
   end

   phase_t        state;
   phase_t        succ;
   phase_t        state_nxt;
   logic [TW-1:0] dur_nxt;
   logic          armed;
   logic          advance;

   assign phase = state;

   // Next-phase selection, duration of that phase, and light decode.
   always_comb begin
      succ      = state;
      dur_nxt   = timer_value;
      ns_light  = OFF;
      ew_light  = OFF;
      advance   = armed && (counter_value == '0);

      case (state)
         NS_G: begin
            ns_light = GRN;
            ew_light = RED;
            succ     = night ? FL_ON : NS_Y;
         end
         NS_Y: begin
            ns_light = YEL;
            ew_light = RED;
            succ     = night ? FL_ON : AR1;
         end
         AR1: begin
            ns_light = RED;
            ew_light = RED;
            succ     = night ? FL_ON : EW_G;
         end
         EW_G: begin
            ns_light = RED;
            ew_light = GRN;
            succ     = night ? FL_ON : EW_Y;
         end
         EW_Y: begin
            ns_light = RED;
            ew_light = YEL;
            succ     = night ? FL_ON : AR2;
         end
         AR2: begin
            ns_light = RED;
            ew_light = RED;
            succ     = night ? FL_ON : NS_G;
         end
         FL_ON: begin
            ns_light = YEL;
            ew_light = YEL;
            succ     = FL_OFF;
         end
         FL_OFF: begin
            succ     = night ? FL_ON : AR2;
         end
         default: begin
            succ     = NS_G;
         end
      endcase

      case (succ)
         NS_G:    dur_nxt = TW'(T_NS_GREEN);
         NS_Y:    dur_nxt = TW'(T_YELLOW);
         AR1:     dur_nxt = TW'(T_ALL_RED);
         EW_G:    dur_nxt = TW'(T_EW_GREEN);
         EW_Y:    dur_nxt = TW'(T_YELLOW);
         AR2:     dur_nxt = TW'(T_ALL_RED);
         FL_ON:   dur_nxt = TW'(T_FLASH_ON);
         FL_OFF:  dur_nxt = TW'(T_FLASH_OFF);
         default: dur_nxt = TW'(T_NS_GREEN);
      endcase

      state_nxt = advance ? succ : state;
   end

   // Phase register; armed blocks a leftover zero from the previous phase
   // from advancing on the entry edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= NS_G;
         timer_value <= TW'(T_NS_GREEN);
         armed       <= 1'b0;
         phase_done  <= 1'b0;
      end else begin
         state      <= state_nxt;
         phase_done <= advance;
         if (advance) begin
            timer_value <= dur_nxt;
            armed       <= 1'b0;
         end else begin
            armed       <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_light_sequencer.sv
// Bench for light_sequencer with a behavioural down-counter on the falling edge.
module tb_light_sequencer;

   logic       clk;
   logic       reset;
   logic       night;
   logic [5:0] counter_value;
   logic [5:0] timer_value;
   logic [2:0] phase;
   logic [2:0] ns_light;
   logic [2:0] ew_light;
   logic       phase_done;

   logic [5:0] cnt;
   logic [5:0] last_tv;
   logic       force_zero;

   int total;
   int bad;

   // Reference tables indexed by phase code.
   int         dur_tab [8];
   logic [2:0] ns_tab  [8];
   logic [2:0] ew_tab  [8];

   light_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .night         (night),
      .counter_value (counter_value),
      .timer_value   (timer_value),
      .phase         (phase),
      .ns_light      (ns_light),
      .ew_light      (ew_light),
      .phase_done    (phase_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Down-counter: reloads when the commanded duration changes, else counts to 0.
   always @(negedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= 6'd30;
         last_tv <= 6'd30;
      end else if (timer_value != last_tv) begin
         cnt     <= timer_value;
         last_tv <= timer_value;
      end else if (cnt != 6'd0) begin
         cnt <= cnt - 6'd1;
      end
   end

   assign counter_value = force_zero ? 6'd0 : cnt;

   function automatic logic [2:0] exp_next(input logic [2:0] ph, input logic nv);
      if (ph <= 3'd5) return nv ? 3'd6 : ((ph == 3'd5) ? 3'd0 : ph + 3'd1);
      if (ph == 3'd6) return 3'd7;
      return nv ? 3'd6 : 3'd5;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Follow n phase transitions; mode 0: first phase joined mid-way,
   // mode 1: first phase starts at reset release, mode 2: first phase just entered.
   // night_bias < 0 leaves night alone, otherwise percent chance of night=1 per cycle.
   task automatic follow(input int n, input int mode, input int night_bias);
      logic [2:0] ph;
      logic       nv;
      logic       exp_pd;
      int         dwell;
      int         exp_dwell;
      for (int k = 0; k < n; k++) begin
         ph    = phase;
         dwell = 0;
         nv    = night;
         do begin
            total++;
            if (ns_light !== ns_tab[ph] || ew_light !== ew_tab[ph]) begin
               bad++;
               $display("FAIL lights ph=%0d: ns=%b ew=%b, want ns=%b ew=%b",
                        ph, ns_light, ew_light, ns_tab[ph], ew_tab[ph]);
            end
            total++;
            if (timer_value !== 6'(dur_tab[ph])) begin
               bad++;
               $display("FAIL timer_value ph=%0d: got %0d want %0d", ph, timer_value, dur_tab[ph]);
            end
            if (!(k == 0 && mode == 0 && dwell == 0)) begin
               exp_pd = (dwell == 0) && !(k == 0 && mode == 1);
               total++;
               if (phase_done !== exp_pd) begin
                  bad++;
                  $display("FAIL phase_done ph=%0d dwell=%0d: got %b want %b",
                           ph, dwell, phase_done, exp_pd);
               end
            end
            if (night_bias >= 0) night = ($urandom_range(0, 99) < night_bias);
            nv = night;
            step();
            dwell++;
         end while (phase === ph && dwell < 200);
         if (dwell >= 200) begin
            total++;
            bad++;
            $display("FAIL timeout ph=%0d: no advance in %0d cycles", ph, dwell);
            return;
         end
         total++;
         if (phase !== exp_next(ph, nv)) begin
            bad++;
            $display("FAIL next ph=%0d night=%b: got %0d want %0d", ph, nv, phase, exp_next(ph, nv));
         end
         exp_dwell = force_zero ? 2 : dur_tab[ph] + 1;
         if (!(k == 0 && mode == 0)) begin
            total++;
            if (k == 0 && mode == 1) begin
               if (dwell != exp_dwell && dwell != exp_dwell - 1) begin
                  bad++;
                  $display("FAIL first_dwell ph=%0d: got %0d want %0d or %0d",
                           ph, dwell, exp_dwell - 1, exp_dwell);
               end
            end else if (dwell != exp_dwell) begin
               bad++;
               $display("FAIL dwell ph=%0d: got %0d want %0d", ph, dwell, exp_dwell);
            end
         end
      end
   endtask

   task automatic wait_phase(input logic [2:0] target, input int want_cnt);
      int i;
      i = 0;
      while (!(phase === target && (want_cnt < 0 || counter_value === 6'(want_cnt))) && i < 500) begin
         step();
         i++;
      end
      if (i >= 500) begin
         total++;
         bad++;
         $display("FAIL wait_phase: phase %0d (count %0d) never seen, at phase %0d",
                  target, want_cnt, phase);
      end
   endtask

   task automatic check_reset_values(input string tag);
      total++;
      if (phase !== 3'd0 || timer_value !== 6'd30 || ns_light !== 3'b001 ||
          ew_light !== 3'b100 || phase_done !== 1'b0) begin
         bad++;
         $display("FAIL %s: phase=%0d tv=%0d ns=%b ew=%b pd=%b, want 0 30 001 100 0",
                  tag, phase, timer_value, ns_light, ew_light, phase_done);
      end
   endtask

   task automatic release_reset();
      @(negedge clk);
      #2;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      night      = 1'b0;
      force_zero = 1'b0;
      reset      = 1'b1;
      step();
      step();
      check_reset_values("reset_values");
      release_reset();
      follow(7, 1, -1);
   endtask

   task automatic test_stale_zero();
      force_zero = 1'b1;
      follow(9, 0, -1);
      force_zero = 1'b0;
   endtask

   task automatic test_night_entry();
      night = 1'b0;
      wait_phase(3'd3, -1);
      step();
      step();
      step();
      night = 1'b1;
      follow(5, 0, -1);
   endtask

   task automatic test_night_exit();
      wait_phase(3'd6, -1);
      step();
      step();
      night = 1'b0;
      follow(4, 0, -1);
   endtask

   task automatic test_reset_mid();
      night = 1'b0;
      wait_phase(3'd1, 2);
      #2;
      reset = 1'b1;
      #1;
      check_reset_values("async_reset");
      step();
      check_reset_values("reset_held");
      release_reset();
      follow(7, 1, -1);
   endtask

   task automatic test_random();
      follow(40, 0, 25);
      night = 1'b0;
      follow(8, 0, -1);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      dur_tab = '{30, 3, 2, 25, 3, 2, 4, 5};
      ns_tab  = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b010, 3'b000};
      ew_tab  = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b010, 3'b000};
      night      = 1'b0;
      force_zero = 1'b0;
      reset      = 1'b1;

      test_reset();
      test_stale_zero();
      test_night_entry();
      test_night_exit();
      test_reset_mid();
      test_random();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
